nasti_traffic_gen: RTL

NASTI_TRAFFIC_GEN -- requirements
Module: nasti_traffic_gen

---
 rtl/nasti_traffic_gen.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/nasti_traffic_gen.sv
// NASTI (AXI4) traffic generator: writes an address-derived pattern in INCR bursts,
// reads it back and reports bad responses or data as a saturating error count.
module nasti_traffic_gen #(
   parameter int C_NASTI_ID_WIDTH   = 1,
   parameter int C_NASTI_ADDR_WIDTH = 32,
   parameter int C_NASTI_DATA_WIDTH = 64,
   parameter int C_BURST_LEN        = 8,
   parameter int C_NUM_BURSTS       = 16,
   parameter logic [C_NASTI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
   input  logic                            core_clk,
   input  logic                            core_rst,
   input  logic                            start,
   output logic [C_NASTI_ID_WIDTH-1:0]     aw_id,
   output logic [C_NASTI_ADDR_WIDTH-1:0]   aw_addr,
   output logic [7:0]                      aw_len,
   output logic [2:0]                      aw_size,
   output logic [1:0]                      aw_burst,
   output logic                            aw_valid,
   input  logic                            aw_ready,
   output logic [C_NASTI_DATA_WIDTH-1:0]   w_data,
   output logic [C_NASTI_DATA_WIDTH/8-1:0] w_strb,
   output logic                            w_last,
   output logic                            w_valid,
   input  logic                            w_ready,
   input  logic [C_NASTI_ID_WIDTH-1:0]     b_id,
   input  logic [1:0]                      b_resp,
   input  logic                            b_valid,
   output logic                            b_ready,
   output logic [C_NASTI_ID_WIDTH-1:0]     ar_id,
   output logic [C_NASTI_ADDR_WIDTH-1:0]   ar_addr,
   output logic [7:0]                      ar_len,
   output logic [2:0]                      ar_size,
   output logic [1:0]                      ar_burst,
   output logic                            ar_valid,
   input  logic                            ar_ready,
   input  logic [C_NASTI_ID_WIDTH-1:0]     r_id,
   input  logic [C_NASTI_DATA_WIDTH-1:0]   r_data,
   input  logic [1:0]                      r_resp,
   input  logic                            r_last,
   input  logic                            r_valid,
   output logic                            r_ready,
   output logic                            busy,
   output logic                            done,
   output logic                            pass,
   output logic [15:0]                     err_count
);
   localparam int              AW         = C_NASTI_ADDR_WIDTH;
   localparam int              BYTES      = C_NASTI_DATA_WIDTH / 8;
   localparam int              WORDS      = C_NASTI_DATA_WIDTH / 32;
   localparam logic [2:0]      SIZE       = 3'($clog2(BYTES));
   localparam logic [7:0]      LEN        = 8'(C_BURST_LEN - 1);
   localparam logic [8:0]      LAST_BEAT  = 9'(C_BURST_LEN - 1);
   localparam logic [15:0]     LAST_BURST = 16'(C_NUM_BURSTS - 1);
   localparam logic [AW-1:0]   STRIDE     = AW'(C_BURST_LEN * BYTES);
   localparam logic [AW-1:0]   BEAT_BYTES = AW'(BYTES);

   typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

   state_t        state_q, state_d;
   logic [15:0]   burst_q, burst_d;
   logic [8:0]    beat_q, beat_d;
   logic [15:0]   err_q, err_d;
   logic          err_clr;
   logic [1:0]    err_inc;
   logic [16:0]   err_sum;

   logic [AW-1:0]                 burst_addr;
   logic [AW-1:0]                 beat_addr;
   logic [31:0]                   pattern;
   logic [C_NASTI_DATA_WIDTH-1:0] exp_data;
   logic                          beat_bad;
   logic                          frame_bad;
   logic                          unused_ids;

   assign burst_addr = C_BASE_ADDR + AW'(burst_q) * STRIDE;
   assign beat_addr  = burst_addr + AW'(beat_q) * BEAT_BYTES;
   assign pattern    = 32'(beat_addr) ^ 32'hA5A5_5A5A;

   generate
      for (genvar gi = 0; gi < WORDS; gi++) begin : g_rep
         assign exp_data[gi*32 +: 32] = pattern;
      end
   endgenerate

   // A beat contributes at most one data/response error; misframing adds one more.
   assign beat_bad   = (r_data != exp_data) || (r_resp != 2'b00);
   assign frame_bad  = r_last && (beat_q != LAST_BEAT);
   assign unused_ids = ^{b_id, r_id};

   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         state_q <= IDLE;
         burst_q <= '0;
         beat_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         burst_q <= burst_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      burst_d = burst_q;
      beat_d  = beat_q;
      err_clr = 1'b0;
      err_inc = 2'd0;
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d = WR_ADDR;
            burst_d = '0;
            beat_d  = '0;
            err_clr = 1'b1;
         end
         WR_ADDR: if (aw_ready) begin
            state_d = WR_DATA;
            beat_d  = '0;
         end
         WR_DATA: if (w_ready) begin
            if (beat_q == LAST_BEAT) begin
               state_d = WR_RESP;
               beat_d  = '0;
            end else begin
               beat_d = beat_q + 9'd1;
            end
         end
         WR_RESP: if (b_valid) begin
            if (b_resp != 2'b00) err_inc = 2'd1;
            if (burst_q == LAST_BURST) begin
               state_d = RD_ADDR;
               burst_d = '0;
            end else begin
               state_d = WR_ADDR;
               burst_d = burst_q + 16'd1;
            end
         end
         RD_ADDR: if (ar_ready) begin
            state_d = RD_DATA;
            beat_d  = '0;
         end
         RD_DATA: if (r_valid) begin
            err_inc = {1'b0, beat_bad} + {1'b0, frame_bad};
            if (r_last) begin
               beat_d = '0;
               if (burst_q == LAST_BURST) begin
                  state_d = DONE;
               end else begin
                  state_d = RD_ADDR;
                  burst_d = burst_q + 16'd1;
               end
            end else begin
               beat_d = beat_q + 9'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      err_sum = {1'b0, err_q} + {15'd0, err_inc};
      if (err_clr)         err_d = '0;
      else if (err_sum[16]) err_d = 16'hFFFF;
      else                 err_d = err_sum[15:0];
   end

   assign aw_id     = '0;
   assign aw_addr   = burst_addr;
   assign aw_len    = LEN;
   assign aw_size   = SIZE;
   assign aw_burst  = 2'b01;
   assign aw_valid  = (state_q == WR_ADDR);
   assign w_data    = exp_data;
   assign w_strb    = '1;
   assign w_valid   = (state_q == WR_DATA);
   assign w_last    = w_valid && (beat_q == LAST_BEAT);
   assign b_ready   = (state_q == WR_RESP);
   assign ar_id     = '0;
   assign ar_addr   = burst_addr;
   assign ar_len    = LEN;
   assign ar_size   = SIZE;
   assign ar_burst  = 2'b01;
   assign ar_valid  = (state_q == RD_ADDR);
   assign r_ready   = (state_q == RD_DATA);
   assign busy      = (state_q != IDLE) && (state_q != DONE);
   assign done      = (state_q == DONE);
   assign pass      = done && (err_q == 16'd0);
   assign err_count = err_q;
endmodule
